mux2_rr_arbiter: RTL and testbench



---
 rtl/mux2_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter/sequencer for a shared 2:1 streaming mux; grants are held for a whole burst.
// Optional forced release after MAX_BURST beats when ARB_BURST_LIMIT_EN is defined.
module mux2_rr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_last,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_last,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          sel,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   sel_q, sel_d;
  logic   cur_s;
  logic   other_valid_s;
  logic   accept_s;
  logic   limit_hit_s;

`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] LAST_BEAT_C = 8'(MAX_BURST - 1);
  logic [7:0] cnt_q, cnt_d;

  // Accepting beat number MAX_BURST forces a release even without last.
  always_comb begin
    limit_hit_s = (cnt_q == LAST_BEAT_C);
  end
`else
  always_comb begin
    limit_hit_s = 1'b0;
  end
`endif

  // Datapath steering: only the granted source sees out_ready; IDLE passes nothing.
  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      GRANT0: begin
        out_valid  = req0_valid;
        out_data   = req0_data;
        out_last   = req0_last;
        req0_ready = out_ready;
      end
      GRANT1: begin
        out_valid  = req1_valid;
        out_data   = req1_data;
        out_last   = req1_last;
        req1_ready = out_ready;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign sel  = sel_q;
  assign busy = (state_q != IDLE);

  // Next-state, priority and select computation.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    sel_d         = sel_q;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d         = cnt_q;
`endif
    cur_s         = (state_q == GRANT1);
    other_valid_s = cur_s ? req0_valid : req1_valid;
    accept_s      = out_valid & out_ready;
    case (state_q)
      IDLE: begin
`ifdef ARB_BURST_LIMIT_EN
        cnt_d = 8'd0;
`endif
        if (req0_valid && req1_valid) begin
          state_d = prio_q ? GRANT1 : GRANT0;
          sel_d   = prio_q;
        end else if (req0_valid) begin
          state_d = GRANT0;
          sel_d   = 1'b0;
        end else if (req1_valid) begin
          state_d = GRANT1;
          sel_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0, GRANT1: begin
        if (accept_s && (out_last || limit_hit_s)) begin
          prio_d = ~cur_s;
`ifdef ARB_BURST_LIMIT_EN
          cnt_d  = 8'd0;
`endif
          // Hand straight over to a waiting peer; otherwise drop to IDLE (one bubble for same source).
          if (other_valid_s) begin
            state_d = cur_s ? GRANT0 : GRANT1;
            sel_d   = ~cur_s;
          end else begin
            state_d = IDLE;
          end
        end else if (accept_s) begin
`ifdef ARB_BURST_LIMIT_EN
          cnt_d = cnt_q + 8'd1;
`endif
          state_d = state_q;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      sel_q   <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus random traffic
// compared against a transaction-level owner/priority model.
module tb_mux2_rr_arbiter;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_last, req0_ready;
  logic req1_valid, req1_last, req1_ready;
  logic [DW-1:0] req0_data, req1_data, out_data;
  logic out_valid, out_last, out_ready, sel, busy;

  mux2_rr_arbiter #(.DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_owner;
  bit m_prio, m_sel;
  int m_beats;
  int b0, b1;
  logic [7:0] acc_log[$];
  logic [7:0] exp_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_prio = 1'b0; m_sel = 1'b0; m_beats = 0;
  endtask

  task automatic model_grant(input int x);
    m_owner = x; m_sel = x[0]; m_beats = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic ev, el, r0, r1;
    logic [7:0] ed;
    ev = 1'b0; el = 1'b0; ed = 8'h00; r0 = 1'b0; r1 = 1'b0;
    if (m_owner == 0) begin
      ev = req0_valid; ed = req0_data; el = req0_last; r0 = out_ready;
    end else if (m_owner == 1) begin
      ev = req1_valid; ed = req1_data; el = req1_last; r1 = out_ready;
    end
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".out_data"}, 32'(out_data), 32'(ed));
    chk({tag, ".out_last"}, 32'(out_last), 32'(el));
    chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
    chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
    chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
    chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
  endtask

  task automatic model_step();
    bit v[2];
    bit l[2];
    v[0] = req0_valid; v[1] = req1_valid; l[0] = req0_last; l[1] = req1_last;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (v[0] && v[1]) model_grant(int'(m_prio));
      else if (v[0]) model_grant(0);
      else if (v[1]) model_grant(1);
    end else if (v[m_owner] && out_ready) begin
      m_beats++;
      if (l[m_owner] || (LIMIT && m_beats == MB)) begin
        m_prio = (m_owner == 0);
        if (v[1 - m_owner]) model_grant(1 - m_owner);
        else m_owner = -1;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_outputs(tag);
    if (out_valid && out_ready) acc_log.push_back(out_data);
    if (req0_valid && req0_ready) b0++;
    if (req1_valid && req1_ready) b1++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag);
    chk({tag, ".count"}, 32'(acc_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < acc_log.size(); i++)
      chk($sformatf("%s.beat%0d", tag, i), 32'(acc_log[i]), 32'(exp_log[i]));
    acc_log.delete();
    exp_log.delete();
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic l);
    req0_valid = v; req0_data = d; req0_last = l;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic l);
    req1_valid = v; req1_data = d; req1_last = l;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    set0(1'b0, 8'h00, 1'b0); set1(1'b0, 8'h00, 1'b0);
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Tie and fairness: 2-beat bursts from both, expected order 0,1,0,1 with no bubble.
    out_ready = 1'b1; b0 = 0; b1 = 0;
    for (int i = 0; i < 9; i++) begin
      set0(b0 < 4, 8'h00 + 8'(b0), b0[0]);
      set1(b1 < 4, 8'h80 + 8'(b1), b1[0]);
      cycle("tie");
    end
    set0(1'b0, 8'h00, 1'b0); set1(1'b0, 8'h00, 1'b0);
    cycle("tie_end");
    exp_log = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h02, 8'h03, 8'h82, 8'h83};
    check_log("tie_order");

    // Single source 3-beat burst.
    set0(1'b1, 8'h11, 1'b0); cycle("single_idle");
    cycle("single_b1");
    set0(1'b1, 8'h22, 1'b0); cycle("single_b2");
    set0(1'b1, 8'h33, 1'b1); cycle("single_b3");
    set0(1'b0, 8'h00, 1'b0); cycle("single_done");
    exp_log = '{8'h11, 8'h22, 8'h33};
    check_log("single");

    // Backpressure: four stalled cycles, then a single accept.
    out_ready = 1'b0;
    set0(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) cycle("stall");
    out_ready = 1'b1; cycle("stall_go");
    set0(1'b0, 8'h00, 1'b0); cycle("stall_done");
    exp_log = '{8'hA5};
    check_log("stall");

    // Same-source re-request: one IDLE bubble between bursts.
    set1(1'b1, 8'h5C, 1'b1);
    for (int i = 0; i < 4; i++) cycle("rereq");
    set1(1'b0, 8'h00, 1'b0); cycle("rereq_done");
    exp_log = '{8'h5C, 8'h5C};
    check_log("rereq");

    // Long req0 burst with req1 waiting; with the limit, req1 cuts in after MB beats.
    b0 = 0; b1 = 0;
    for (int i = 0; i < 20; i++) begin
      set0(b0 < 6, 8'h40 + 8'(b0), b0 == 5);
      set1(b1 < 1, 8'h90, 1'b1);
      cycle("limit");
    end
    chk("limit.timeout", 32'(b0 == 6 && b1 == 1), 32'd1);
    set0(1'b0, 8'h00, 1'b0); set1(1'b0, 8'h00, 1'b0);
    cycle("limit_done");
    if (LIMIT) exp_log = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h90, 8'h44, 8'h45};
    else       exp_log = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h90};
    check_log("limit");

    // Reset mid-burst in GRANT1 after two accepted beats.
    set1(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 3; i++) cycle("mid");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    cycle("in_rst");
    set1(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst");
    acc_log.delete();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      set0($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
      set1($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
      out_ready = $urandom_range(0, 3) != 0;
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
